chan_512_fir_coef_loader: RTL and testbench
===========================================

// Module: chan_512_fir_coef_loader
// PURPOSE
//  Sits directly downstream of the FIR b24/b25 software-register stage in chan_512.
//  Takes the packed 32-bit register word and debounces it, since an OPB write can land
//  one halfword at a time. It arms a coefficient swap, then applies b24/b25 to the FIR
//  taps only on a frame_sync boundary, so the 512-channel FIR never mixes old and new taps.
// PARAMETERS
//  COEF_WIDTH     16      width of each coefficient; word = {b24, b25}, 2*COEF_WIDTH = 32
//  STABLE_CYCLES  4       consecutive cycles the word must be unchanged before arming (>=1)
//  CNT_WIDTH      8       width of update_count
//  RESET_B24      16'h0   coef_b24 value after reset
//  RESET_B25      16'h0   coef_b25 value after reset
// PORTS
//  user_clk      in   1    FIR/user clock; all logic on its rising edge
//  user_rst_n    in   1    asynchronous active-low reset
//  reg_data_in   in   32   software register word: [31:16]=b24, [15:0]=b25
//  frame_sync    in   1    1-cycle pulse marking the first sample of a 512-channel frame
//  coef_b24      out  16   active b24 tap coefficient
//  coef_b25      out  16   active b25 tap coefficient
//  coef_update   out  1    1-cycle pulse in the cycle the new coef_b24/coef_b25 first appear
//  pending       out  1    high while a debounced new word waits for frame_sync (ARMED)
//  update_count  out  8    number of applied updates, modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset (async assert; release synchronous to user_clk):
//   - coef_b24=RESET_B24, coef_b25=RESET_B25; coef_update=0; pending=0.
//   - update_count=0; state=IDLE; cnt=0.
//   - cap and active both = {RESET_B24,RESET_B25}.
//  Input stage: cap <= reg_data_in every cycle (1-cycle register).
//   - The FSM compares cap only and never reads reg_data_in directly.
//  active = {coef_b24,coef_b25}. cand is the candidate word. cnt counts stable cycles.
//  IDLE:
//   - cap != active: cand<=cap, cnt<=0, go to SETTLE. Otherwise stay.
//  SETTLE:
//   - cap == active: go to IDLE (the write reverted).
//   - else cap != cand: cand<=cap, cnt<=0, stay.
//   - else cnt == STABLE_CYCLES-1: go to ARMED.
//   - else cnt<=cnt+1.
//  ARMED (pending=1):
//   - cap != cand: cand<=cap, cnt<=0, go to SETTLE. Change beats frame_sync in the same cycle.
//   - else frame_sync=1: active<=cand, coef_update<=1, update_count<=update_count+1 (wraps),
//     go to IDLE.
//  frame_sync outside ARMED is ignored. coef_update is high for exactly one cycle.
//  Latency: reg_data_in changes at cycle t and then holds.
//   - cap holds the new word at t+1; SETTLE at t+2; ARMED and pending=1 at t+2+STABLE_CYCLES.
//   - frame_sync sampled at cycle s in ARMED: coefs and coef_update change at s+1.
//  Both halves always update together. No partial-halfword update ever reaches the outputs.
//  pending is a registered decode of state==ARMED. All outputs are registered.
//  If reg_data_in differs from the reset value after reset, normal flow loads it.
//  Reset mid-operation (SETTLE/ARMED) discards cand; coefs return to the RESET values.
// TESTING
//  1. Reset, reg_data_in=32'h0: hold 100 cycles with frame_sync every 16 cycles
//     -> no coef_update, pending=0, update_count=0.
//  2. Write 32'h1234_ABCD at t=10, frame_sync at t=30 -> pending=1 at t=16.
//     At t=31: coef_b24=16'h1234, coef_b25=16'hABCD, coef_update=1 for 1 cycle, update_count=1.
//  3. Halfword writes: 32'h5555_0000 at t=10, then 32'h5555_6666 at t=12, frame_sync at t=40
//     -> single update to 5555/6666; the intermediate 5555/0000 is never output.
//  4. Word changes in the same cycle as frame_sync while ARMED -> no update; FSM to SETTLE.
//     Update applies on the next frame_sync after re-arming.
//  5. Write new word, then revert to active within 2 cycles -> FSM returns to IDLE.
//     pending never asserts; coefs unchanged.
//  6. Apply 257 distinct updates -> update_count=1. Assert user_rst_n=0 while ARMED
//     -> coefs/pending/count reset immediately (async).

Source files
------------

// File: rtl/chan_512_fir_coef_loader_if.sv
// ============================================================================
// Module   : chan_512_fir_coef_loader_if
// Purpose  : Register-word input and active-coefficient output bundle for the
//            chan_512 FIR b24/b25 coefficient loader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface chan_512_fir_coef_loader_if #(
  parameter int COEF_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic [2*COEF_WIDTH-1:0] reg_data_in;
  logic                    frame_sync;
  logic [COEF_WIDTH-1:0]   coef_b24;
  logic [COEF_WIDTH-1:0]   coef_b25;
  logic                    coef_update;
  logic                    pending;
  logic [CNT_WIDTH-1:0]    update_count;

  // Master is the register stage / frame timing side; slave is the loader.
  modport master (
    output reg_data_in, frame_sync,
    input  coef_b24, coef_b25, coef_update, pending, update_count
  );

  modport slave (
    input  reg_data_in, frame_sync,
    output coef_b24, coef_b25, coef_update, pending, update_count
  );
endinterface

`default_nettype wire

// File: rtl/chan_512_fir_coef_loader.sv
// ============================================================================
// Module   : chan_512_fir_coef_loader
// Purpose  : Debounces the packed {b24,b25} register word and swaps both FIR
//            taps together only on a frame_sync boundary.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module chan_512_fir_coef_loader #(
  parameter int                    COEF_WIDTH    = 16,
  parameter int                    STABLE_CYCLES = 4,
  parameter int                    CNT_WIDTH     = 8,
  parameter logic [COEF_WIDTH-1:0] RESET_B24     = '0,
  parameter logic [COEF_WIDTH-1:0] RESET_B25     = '0
) (
  input wire logic                   user_clk,
  input wire logic                   user_rst_n,
  chan_512_fir_coef_loader_if.slave  bus
);

  localparam int                  c_word_w     = 2 * COEF_WIDTH;
  localparam int                  c_cnt_w      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_last   = c_cnt_w'(STABLE_CYCLES - 1);
  localparam logic [c_word_w-1:0] c_reset_word = {RESET_B24, RESET_B25};

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_settle = 2'd1;
  localparam logic [1:0] c_armed  = 2'd2;

  logic [c_word_w-1:0]  r_cap;
  logic [c_word_w-1:0]  r_cand;
  logic [c_word_w-1:0]  r_active;
  logic [1:0]           r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_update;
  logic                 r_pending;
  logic [CNT_WIDTH-1:0] r_count;

  logic [1:0]           w_state_nxt;
  logic [c_word_w-1:0]  w_cand_nxt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 w_apply;
  logic [c_word_w-1:0]  w_active_nxt;
  logic                 w_update_nxt;
  logic                 w_pending_nxt;
  logic [CNT_WIDTH-1:0] w_count_nxt;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_cap     <= c_reset_word;
      r_cand    <= c_reset_word;
      r_active  <= c_reset_word;
      r_state   <= c_idle;
      r_cnt     <= '0;
      r_update  <= 1'b0;
      r_pending <= 1'b0;
      r_count   <= '0;
    end else begin
      r_cap     <= bus.reg_data_in;
      r_cand    <= w_cand_nxt;
      r_active  <= w_active_nxt;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_update  <= w_update_nxt;
      r_pending <= w_pending_nxt;
      r_count   <= w_count_nxt;
    end
  end

  // Only the captured word is compared, so a halfword landing mid-cycle restarts the settle count.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_apply     = 1'b0;
    case (r_state)
      c_idle: begin
        if (r_cap != r_active) begin
          w_cand_nxt  = r_cap;
          w_cnt_nxt   = '0;
          w_state_nxt = c_settle;
        end
      end
      c_settle: begin
        if (r_cap == r_active) begin
          w_state_nxt = c_idle;
        end else if (r_cap != r_cand) begin
          w_cand_nxt = r_cap;
          w_cnt_nxt  = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = c_armed;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      c_armed: begin
        // A late write wins over frame_sync so a half-settled word is never applied.
        if (r_cap != r_cand) begin
          w_cand_nxt  = r_cap;
          w_cnt_nxt   = '0;
          w_state_nxt = c_settle;
        end else if (bus.frame_sync) begin
          w_apply     = 1'b1;
          w_state_nxt = c_idle;
        end
      end
      default: begin
        w_state_nxt = c_idle;
      end
    endcase
  end

  always_comb begin
    w_active_nxt  = w_apply ? r_cand : r_active;
    w_update_nxt  = w_apply;
    w_pending_nxt = (w_state_nxt == c_armed);
    w_count_nxt   = w_apply ? r_count + CNT_WIDTH'(1) : r_count;
  end

  assign bus.coef_b24     = r_active[c_word_w-1:COEF_WIDTH];
  assign bus.coef_b25     = r_active[COEF_WIDTH-1:0];
  assign bus.coef_update  = r_update;
  assign bus.pending      = r_pending;
  assign bus.update_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_chan_512_fir_coef_loader.sv
// ============================================================================
// Module   : tb_chan_512_fir_coef_loader
// Purpose  : Directed self-checking bench for chan_512_fir_coef_loader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_chan_512_fir_coef_loader;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  chan_512_fir_coef_loader_if #(.COEF_WIDTH(16), .CNT_WIDTH(8)) bus ();

  chan_512_fir_coef_loader #(
    .COEF_WIDTH   (16),
    .STABLE_CYCLES(4),
    .CNT_WIDTH    (8),
    .RESET_B24    (16'h0000),
    .RESET_B25    (16'h0000)
  ) dut (
    .user_clk  (clk),
    .user_rst_n(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.reg_data_in = 32'h0;
    bus.frame_sync  = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({bus.coef_b24, bus.coef_b25} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_coefs: got %h expected %h", {bus.coef_b24, bus.coef_b25}, 32'h0);
    end
    vectors++;
    if (bus.update_count !== 8'd0 || bus.pending !== 1'b0 || bus.coef_update !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got cnt=%0d pend=%b upd=%b expected 0/0/0",
               bus.update_count, bus.pending, bus.coef_update);
    end
    for (int i = 0; i < 100; i++) begin
      bus.frame_sync = (i % 16 == 0);
      step(1);
      vectors++;
      if (bus.coef_update !== 1'b0 || bus.pending !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_sync_ignored: got upd=%b pend=%b expected 0/0 at i=%0d",
                 bus.coef_update, bus.pending, i);
      end
    end
    bus.frame_sync = 1'b0;
    vectors++;
    if (bus.update_count !== 8'd0) begin
      miscompares++;
      $display("FAIL idle_count: got %0d expected 0", bus.update_count);
    end
  endtask

  task automatic test_single_write();
    bus.reg_data_in = 32'h1234_ABCD;   // cycle t=10
    step(5);
    vectors++;
    if (bus.pending !== 1'b0) begin
      miscompares++;
      $display("FAIL pending_early: got %b expected 0", bus.pending);
    end
    step(1);                           // t=16
    vectors++;
    if (bus.pending !== 1'b1) begin
      miscompares++;
      $display("FAIL pending_arm: got %b expected 1", bus.pending);
    end
    step(14);                          // t=30
    vectors++;
    if (bus.coef_update !== 1'b0 || {bus.coef_b24, bus.coef_b25} !== 32'h0) begin
      miscompares++;
      $display("FAIL hold_until_sync: got upd=%b coefs=%h expected 0/00000000",
               bus.coef_update, {bus.coef_b24, bus.coef_b25});
    end
    bus.frame_sync = 1'b1;
    step(1);                           // t=31
    bus.frame_sync = 1'b0;
    vectors++;
    if (bus.coef_b24 !== 16'h1234 || bus.coef_b25 !== 16'hABCD) begin
      miscompares++;
      $display("FAIL single_coefs: got %h/%h expected 1234/abcd", bus.coef_b24, bus.coef_b25);
    end
    vectors++;
    if (bus.coef_update !== 1'b1 || bus.update_count !== 8'd1 || bus.pending !== 1'b0) begin
      miscompares++;
      $display("FAIL single_flags: got upd=%b cnt=%0d pend=%b expected 1/1/0",
               bus.coef_update, bus.update_count, bus.pending);
    end
    step(1);
    vectors++;
    if (bus.coef_update !== 1'b0 || bus.coef_b24 !== 16'h1234) begin
      miscompares++;
      $display("FAIL single_pulse: got upd=%b b24=%h expected 0/1234", bus.coef_update, bus.coef_b24);
    end
  endtask

  task automatic test_halfword();
    bus.reg_data_in = 32'h5555_0000;   // t=10
    step(2);
    bus.reg_data_in = 32'h5555_6666;   // t=12
    for (int c = 13; c <= 40; c++) begin
      step(1);
      if (c == 17) begin
        vectors++;
        if (bus.pending !== 1'b0) begin
          miscompares++;
          $display("FAIL half_pending_early: got %b expected 0", bus.pending);
        end
      end
      if (c == 18) begin
        vectors++;
        if (bus.pending !== 1'b1) begin
          miscompares++;
          $display("FAIL half_pending_arm: got %b expected 1", bus.pending);
        end
      end
      vectors++;
      if (bus.coef_update !== 1'b0 || {bus.coef_b24, bus.coef_b25} !== 32'h1234_ABCD) begin
        miscompares++;
        $display("FAIL half_no_partial: got upd=%b coefs=%h expected 0/1234abcd at t=%0d",
                 bus.coef_update, {bus.coef_b24, bus.coef_b25}, c);
      end
    end
    bus.frame_sync = 1'b1;             // t=40
    step(1);
    bus.frame_sync = 1'b0;
    vectors++;
    if ({bus.coef_b24, bus.coef_b25} !== 32'h5555_6666 || bus.coef_update !== 1'b1
        || bus.update_count !== 8'd2) begin
      miscompares++;
      $display("FAIL half_update: got coefs=%h upd=%b cnt=%0d expected 55556666/1/2",
               {bus.coef_b24, bus.coef_b25}, bus.coef_update, bus.update_count);
    end
  endtask

  task automatic test_change_on_sync();
    bus.reg_data_in = 32'h0F0F_F0F0;
    step(6);
    vectors++;
    if (bus.pending !== 1'b1) begin
      miscompares++;
      $display("FAIL race_armed: got %b expected 1", bus.pending);
    end
    bus.reg_data_in = 32'h7777_8888;
    step(1);                           // new word now in capture register
    bus.frame_sync = 1'b1;
    step(1);
    bus.frame_sync = 1'b0;
    vectors++;
    if (bus.coef_update !== 1'b0 || bus.pending !== 1'b0
        || {bus.coef_b24, bus.coef_b25} !== 32'h5555_6666 || bus.update_count !== 8'd2) begin
      miscompares++;
      $display("FAIL race_blocked: got upd=%b pend=%b coefs=%h cnt=%0d expected 0/0/55556666/2",
               bus.coef_update, bus.pending, {bus.coef_b24, bus.coef_b25}, bus.update_count);
    end
    step(3);
    vectors++;
    if (bus.pending !== 1'b0) begin
      miscompares++;
      $display("FAIL race_rearm_early: got %b expected 0", bus.pending);
    end
    step(1);
    vectors++;
    if (bus.pending !== 1'b1) begin
      miscompares++;
      $display("FAIL race_rearm: got %b expected 1", bus.pending);
    end
    bus.frame_sync = 1'b1;
    step(1);
    bus.frame_sync = 1'b0;
    vectors++;
    if ({bus.coef_b24, bus.coef_b25} !== 32'h7777_8888 || bus.coef_update !== 1'b1
        || bus.update_count !== 8'd3) begin
      miscompares++;
      $display("FAIL race_update: got coefs=%h upd=%b cnt=%0d expected 77778888/1/3",
               {bus.coef_b24, bus.coef_b25}, bus.coef_update, bus.update_count);
    end
  endtask

  task automatic test_revert();
    bus.reg_data_in = 32'h1111_2222;
    step(2);
    bus.reg_data_in = 32'h7777_8888;
    for (int i = 0; i < 12; i++) begin
      bus.frame_sync = (i % 3 == 0);
      step(1);
      vectors++;
      if (bus.pending !== 1'b0 || bus.coef_update !== 1'b0
          || {bus.coef_b24, bus.coef_b25} !== 32'h7777_8888) begin
        miscompares++;
        $display("FAIL revert_idle: got pend=%b upd=%b coefs=%h expected 0/0/77778888 at i=%0d",
                 bus.pending, bus.coef_update, {bus.coef_b24, bus.coef_b25}, i);
      end
    end
    bus.frame_sync = 1'b0;
  endtask

  task automatic test_wrap_and_async_reset();
    logic [31:0] word;
    apply_reset();
    for (int i = 0; i < 257; i++) begin
      word = {16'(i + 1), 16'(16'hFFFF - i)};
      bus.reg_data_in = word;
      step(6);
      bus.frame_sync = 1'b1;
      step(1);
      bus.frame_sync = 1'b0;
      vectors++;
      if ({bus.coef_b24, bus.coef_b25} !== word || bus.coef_update !== 1'b1
          || bus.update_count !== 8'((i + 1) % 256)) begin
        miscompares++;
        $display("FAIL wrap_update: got coefs=%h upd=%b cnt=%0d expected %h/1/%0d",
                 {bus.coef_b24, bus.coef_b25}, bus.coef_update, bus.update_count,
                 word, (i + 1) % 256);
      end
    end
    vectors++;
    if (bus.update_count !== 8'd1) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d expected 1", bus.update_count);
    end
    bus.reg_data_in = 32'hCAFE_F00D;
    step(6);
    vectors++;
    if (bus.pending !== 1'b1) begin
      miscompares++;
      $display("FAIL async_armed: got %b expected 1", bus.pending);
    end
    #2;
    rst_n = 1'b0;                      // mid-cycle, no clock edge
    #1;
    vectors++;
    if ({bus.coef_b24, bus.coef_b25} !== 32'h0 || bus.pending !== 1'b0
        || bus.update_count !== 8'd0 || bus.coef_update !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got coefs=%h pend=%b cnt=%0d upd=%b expected 0/0/0/0",
               {bus.coef_b24, bus.coef_b25}, bus.pending, bus.update_count, bus.coef_update);
    end
    step(2);
    rst_n = 1'b1;
    step(6);
    vectors++;
    if (bus.pending !== 1'b1 || {bus.coef_b24, bus.coef_b25} !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_reload: got pend=%b coefs=%h expected 1/00000000",
               bus.pending, {bus.coef_b24, bus.coef_b25});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.reg_data_in = 32'h0;
    bus.frame_sync  = 1'b0;
    test_reset();
    test_single_write();
    test_halfword();
    test_change_on_sync();
    test_revert();
    test_wrap_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
